// File: rtl/cv32e40s_rnd_arbiter_pkg.sv
// Shared types and helpers for the random-source arbiter and its round-robin picker.
package cv32e40s_rnd_arbiter_pkg;

   typedef enum logic {
      WARMUP = 1'b0,
      READY  = 1'b1
   } rnd_arb_state_e;

   localparam int RND_ARB_NUM_REQ_MAX    = 8;
   localparam int RND_ARB_WARMUP_DEFAULT = 8;

   // One-hot to binary index; an all-zero vector maps to index 0.
   function automatic logic [2:0] onehot_to_idx(input logic [RND_ARB_NUM_REQ_MAX-1:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < RND_ARB_NUM_REQ_MAX; i++) begin
         idx = idx | (oh[i] ? 3'(i) : 3'd0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/cv32e40s_rr_picker.sv
// Combinational round-robin picker: grants the first set request at or above ptr, wrapping around.
module cv32e40s_rr_picker #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt
);

   // Walk the requesters starting at ptr; the first hit blocks all later ones.
   always_comb begin
      int   idx;
      logic found_s;
      logic hit_s;
      gnt     = {NUM_REQ{1'b0}};
      found_s = 1'b0;
      hit_s   = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx      = (int'(ptr) + i) % NUM_REQ;
         hit_s    = !found_s && req[idx];
         gnt[idx] = hit_s;
         found_s  = found_s | hit_s;
      end
   end

endmodule

// File: rtl/cv32e40s_rnd_arbiter.sv
// Owns the LFSR controls: warm-up after reset/seed/lockup, then round-robin sharing of random words.
module cv32e40s_rnd_arbiter
   import cv32e40s_rnd_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = 3,
   parameter int WARMUP_SHIFTS = RND_ARB_WARMUP_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable_i,
   input  logic [31:0]        seed_i,
   input  logic               seed_we_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [31:0]        rdata_o,
   output logic               ready_o,
   output logic               alert_o,
   output logic               lfsr_enable_o,
   output logic [31:0]        lfsr_seed_o,
   output logic               lfsr_seed_we_o,
   output logic               lfsr_shift_o,
   input  logic [31:0]        lfsr_data_i,
   input  logic               lfsr_lockup_i
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WCNT_W = $clog2(WARMUP_SHIFTS + 1);
   localparam logic [WCNT_W-1:0] WARMUP_INIT = WCNT_W'(WARMUP_SHIFTS);
   localparam logic [WCNT_W-1:0] WCNT_ONE    = WCNT_W'(1);
   localparam logic [2:0]        LAST_IDX    = 3'(NUM_REQ - 1);

   rnd_arb_state_e     state_r, state_n_s;
   logic [WCNT_W-1:0]  wcnt_r, wcnt_n_s;
   logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_n_s;
   logic               alert_r, alert_n_s;
   logic [NUM_REQ-1:0] pick_s;
   logic [2:0]         pick_idx_s;
   logic               grant_s;

   cv32e40s_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req (req_i),
      .ptr (rr_ptr_r),
      .gnt (pick_s)
   );

   assign pick_idx_s = onehot_to_idx(RND_ARB_NUM_REQ_MAX'(pick_s));

   // A grant needs READY, an enabled source, a request, and no seed/lockup event this cycle.
   assign grant_s = (state_r == READY) && enable_i && (|req_i) && !seed_we_i && !lfsr_lockup_i;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= WARMUP;
         wcnt_r   <= WARMUP_INIT;
         rr_ptr_r <= {PTR_W{1'b0}};
         alert_r  <= 1'b0;
      end else begin
         state_r  <= state_n_s;
         wcnt_r   <= wcnt_n_s;
         rr_ptr_r <= rr_ptr_n_s;
         alert_r  <= alert_n_s;
      end
   end

   // Next-state logic; seed write outranks lockup, which outranks normal operation.
   always_comb begin
      state_n_s  = state_r;
      wcnt_n_s   = wcnt_r;
      rr_ptr_n_s = rr_ptr_r;
      alert_n_s  = 1'b0;
      if (seed_we_i) begin
         state_n_s = WARMUP;
         wcnt_n_s  = WARMUP_INIT;
      end else if (lfsr_lockup_i) begin
         state_n_s = WARMUP;
         wcnt_n_s  = WARMUP_INIT;
         alert_n_s = 1'b1;
      end else begin
         case (state_r)
            WARMUP: begin
               if (enable_i) begin
                  wcnt_n_s = wcnt_r - WCNT_ONE;
                  if (wcnt_r == WCNT_ONE) begin
                     state_n_s = READY;
                  end else begin
                     state_n_s = WARMUP;
                  end
               end else begin
                  wcnt_n_s = wcnt_r;
               end
            end
            READY: begin
               if (grant_s) begin
                  if (pick_idx_s == LAST_IDX) begin
                     rr_ptr_n_s = {PTR_W{1'b0}};
                  end else begin
                     rr_ptr_n_s = PTR_W'(pick_idx_s + 3'd1);
                  end
               end else begin
                  rr_ptr_n_s = rr_ptr_r;
               end
            end
            default: begin
               state_n_s = WARMUP;
               wcnt_n_s  = WARMUP_INIT;
            end
         endcase
      end
   end

   // Output decode; everything is held at zero while reset is asserted.
   always_comb begin
      gnt_o          = {NUM_REQ{1'b0}};
      rdata_o        = 32'h0;
      ready_o        = 1'b0;
      alert_o        = 1'b0;
      lfsr_enable_o  = 1'b0;
      lfsr_seed_o    = 32'h0;
      lfsr_seed_we_o = 1'b0;
      lfsr_shift_o   = 1'b0;
      if (rst) begin
         gnt_o = {NUM_REQ{1'b0}};
      end else begin
         ready_o       = (state_r == READY);
         alert_o       = alert_r;
         lfsr_enable_o = enable_i;
         if (seed_we_i) begin
            lfsr_seed_we_o = 1'b1;
            lfsr_seed_o    = seed_i;
         end else if (lfsr_lockup_i) begin
            lfsr_shift_o = 1'b0;
         end else begin
            case (state_r)
               WARMUP: lfsr_shift_o = enable_i;
               READY: begin
                  if (grant_s) begin
                     gnt_o        = pick_s;
                     rdata_o      = lfsr_data_i;
                     lfsr_shift_o = 1'b1;
                  end else begin
                     lfsr_shift_o = 1'b0;
                  end
               end
               default: lfsr_shift_o = 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cv32e40s_rnd_arbiter.sv
// Table-driven bench for cv32e40s_rnd_arbiter with a scoreboard queue of expected outputs.
module tb_cv32e40s_rnd_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable_i = 1'b0;
   logic [31:0] seed_i = 32'h0;
   logic        seed_we_i = 1'b0;
   logic [2:0]  req_i = 3'b000;
   logic [2:0]  gnt_o;
   logic [31:0] rdata_o;
   logic        ready_o, alert_o, lfsr_enable_o, lfsr_seed_we_o, lfsr_shift_o;
   logic [31:0] lfsr_seed_o;
   logic [31:0] lfsr_data_i = 32'h0;
   logic        lfsr_lockup_i = 1'b0;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] SEED = 32'h1234_5678;

   typedef struct {
      logic       rst, en;
      logic [2:0] req;
      logic       swe, lock;
      logic [2:0] gnt;
      logic       shift, alert, ready;
   } vec_t;

   typedef struct {
      logic [2:0]  gnt;
      logic [31:0] rdata;
      logic        shift, alert, ready, swe, en;
      logic [31:0] seed;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   cv32e40s_rnd_arbiter #(.NUM_REQ(3), .WARMUP_SHIFTS(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable_i       (enable_i),
      .seed_i         (seed_i),
      .seed_we_i      (seed_we_i),
      .req_i          (req_i),
      .gnt_o          (gnt_o),
      .rdata_o        (rdata_o),
      .ready_o        (ready_o),
      .alert_o        (alert_o),
      .lfsr_enable_o  (lfsr_enable_o),
      .lfsr_seed_o    (lfsr_seed_o),
      .lfsr_seed_we_o (lfsr_seed_we_o),
      .lfsr_shift_o   (lfsr_shift_o),
      .lfsr_data_i    (lfsr_data_i),
      .lfsr_lockup_i  (lfsr_lockup_i)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic e, logic [2:0] q, logic s, logic l,
                               logic [2:0] g, logic sh, logic a, logic rd);
      vec_t v;
      v.rst = r; v.en = e; v.req = q; v.swe = s; v.lock = l;
      v.gnt = g; v.shift = sh; v.alert = a; v.ready = rd;
      return v;
   endfunction

   task automatic add(int n, vec_t v);
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      int   n;
      logic found;

      // reset, warm-up, then round robin over 111
      add(2, mk(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
      add(8, mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0));
      add(1, mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
      add(1, mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1));
      add(1, mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1));
      add(1, mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
      // seed write in READY
      add(1, mk(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1));
      add(8, mk(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0));
      add(1, mk(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
      // lockup in READY, alert the cycle after
      add(1, mk(1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1));
      add(1, mk(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0));
      add(7, mk(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0));
      add(1, mk(1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
      // seed and lockup together; then freeze at wcnt=5 for 3 cycles
      add(1, mk(1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1));
      add(3, mk(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0));
      add(3, mk(1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
      add(5, mk(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0));
      // fairness on 101 starting from rr_ptr=1
      add(1, mk(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1));
      add(1, mk(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
      add(1, mk(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1));
      add(1, mk(1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
      // disabled and idle READY
      add(1, mk(1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1));
      add(1, mk(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1));
      // reset in a would-be grant cycle; pointer must restart at 0
      add(1, mk(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
      add(8, mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0));
      add(1, mk(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));

      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         rst           = tbl[i].rst;
         enable_i      = tbl[i].en;
         req_i         = tbl[i].req;
         seed_we_i     = tbl[i].swe;
         seed_i        = tbl[i].swe ? SEED : $urandom;
         lfsr_lockup_i = tbl[i].lock;
         lfsr_data_i   = $urandom;
         e.gnt   = tbl[i].gnt;
         e.rdata = (tbl[i].gnt != 3'b000) ? lfsr_data_i : 32'h0;
         e.shift = tbl[i].shift;
         e.alert = tbl[i].alert;
         e.ready = tbl[i].ready;
         e.swe   = tbl[i].swe & ~tbl[i].rst;
         e.en    = tbl[i].en & ~tbl[i].rst;
         e.seed  = SEED;
         sb.push_back(e);

         @(negedge clk);
         if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard", i), 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d gnt", i), {29'd0, gnt_o}, {29'd0, e.gnt});
            chk($sformatf("v%0d rdata", i), rdata_o, e.rdata);
            chk($sformatf("v%0d shift", i), {31'd0, lfsr_shift_o}, {31'd0, e.shift});
            chk($sformatf("v%0d alert", i), {31'd0, alert_o}, {31'd0, e.alert});
            chk($sformatf("v%0d ready", i), {31'd0, ready_o}, {31'd0, e.ready});
            chk($sformatf("v%0d seed_we", i), {31'd0, lfsr_seed_we_o}, {31'd0, e.swe});
            chk($sformatf("v%0d lfsr_en", i), {31'd0, lfsr_enable_o}, {31'd0, e.en});
            if (e.swe) chk($sformatf("v%0d seed", i), lfsr_seed_o, e.seed);
         end
      end

      // first-grant latency after reset, bounded wait
      @(posedge clk);
      #1;
      rst = 1'b1; seed_we_i = 1'b0; lfsr_lockup_i = 1'b0; enable_i = 1'b1; req_i = 3'b010;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n = 0;
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (gnt_o != 3'b000) begin
            found = 1'b1;
            break;
         end
         n++;
      end
      chk("latency found", {31'd0, found}, 32'd1);
      chk("latency cycles", n, 32'd8);
      chk("latency gnt", {29'd0, gnt_o}, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cv32e40s_rnd_arbiter.md
# cv32e40s_rnd_arbiter

Controller and arbiter for the core's single 32-bit pseudo-random source. It owns the LFSR's shift and seed controls. It runs a warm-up sequence after reset, after every seed write and after every lockup recovery. It then shares random words between NUM_REQ requesters (dummy-instruction insertion, hint randomisation, etc.) with round-robin fairness, so that no two consumers ever receive the same word.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters; legal range 2..8.
- WARMUP_SHIFTS, 8: LFSR shifts performed before grants are allowed; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enable_i  in  1  random source enabled (from CSR). Passed through to lfsr_enable_o.
- seed_i  in  32  seed value from CSR write.
- seed_we_i  in  1  seed write strobe, single cycle.
- req_i  in  NUM_REQ  per-requester request. Level-held until granted.
- gnt_o  out  NUM_REQ  one-hot grant; at most one bit set.
- rdata_o  out  32  random word. Valid for the requester whose gnt_o bit is high.
- ready_o  out  1  high in READY state.
- alert_o  out  1  single-cycle pulse: lockup detected.
- lfsr_enable_o  out  1  LFSR enable.
- lfsr_seed_o  out  32  LFSR seed.
- lfsr_seed_we_o  out  1  LFSR seed write.
- lfsr_shift_o  out  1  LFSR shift.
- lfsr_data_i  in  32  current LFSR state.
- lfsr_lockup_i  in  1  LFSR all-zero lockup flag. The LFSR self-reloads its default seed on the next edge.

## Operation
- FSM has two states, WARMUP and READY, plus a warm-up counter wcnt of width $clog2(WARMUP_SHIFTS+1). It also holds a round-robin pointer rr_ptr of width $clog2(NUM_REQ).
- Reset sets: state=WARMUP, wcnt=WARMUP_SHIFTS, rr_ptr=0, alert register=0.
- While rst is high, all outputs are forced to 0.
- Event priority, highest first: seed_we_i, then lfsr_lockup_i, then normal operation.
- seed_we_i (any state):
  - lfsr_seed_we_o=1 and lfsr_seed_o=seed_i in the same cycle.
  - gnt_o=0 and lfsr_shift_o=0.
  - Next state is WARMUP with wcnt=WARMUP_SHIFTS.
  - No alert, even if lfsr_lockup_i is also high.
- lfsr_lockup_i without seed_we_i (any state):
  - gnt_o=0 and lfsr_shift_o=0.
  - alert_o pulses high the next cycle.
  - Next state is WARMUP with wcnt=WARMUP_SHIFTS.
- WARMUP:
  - lfsr_shift_o=1 when enable_i=1; wcnt decrements on each such cycle.
  - When enable_i=0, the counter and shift freeze.
  - When wcnt reaches 1 with a shift, the next state is READY.
  - gnt_o=0 throughout.
- READY:
  - With enable_i=1 and any req_i bit set, grant the first set bit searching from rr_ptr upward, with wrap-around.
  - Grant cycle: gnt_o one-hot, rdata_o=lfsr_data_i, lfsr_shift_o=1. rr_ptr becomes the granted index + 1, wrapping from NUM_REQ-1 to 0.
  - With enable_i=0: gnt_o=0 and no shift; the state stays READY.
- rdata_o = lfsr_data_i whenever gnt_o is non-zero; 0 otherwise.
- lfsr_enable_o = enable_i. It is a combinational pass-through.

## Timing
- Grant is combinational from req_i in READY: zero-cycle latency. One grant per cycle at most.
- Each grant shifts the LFSR, so back-to-back grants in consecutive cycles carry distinct words.
- Post-reset, the first grant is possible in cycle WARMUP_SHIFTS after reset deassertion, given enable_i=1 throughout. The same latency applies after a seed write or a lockup.
- alert_o is registered: it asserts exactly one cycle after the lockup cycle and lasts one cycle.
- A requester must hold req_i until it sees gnt_o. Dropping req_i without a grant is legal; no state is kept per requester.
- Reset mid-WARMUP or mid-grant: the next cycle is the reset state. No partial grant survives.

## Structure
- Shared package holds:
  - typedef rnd_arb_state_e {WARMUP, READY};
  - localparams RND_ARB_NUM_REQ_MAX=8 and RND_ARB_WARMUP_DEFAULT=8.
- One natural sub-module: cv32e40s_rr_picker. It is a combinational round-robin priority picker with inputs req and ptr and output one-hot gnt, and it is reusable by other arbiters.
- The LFSR itself stays outside this block; connection is via the lfsr_* ports only.

## Test plan
- Reset release with enable_i=1, req_i=3'b111, WARMUP_SHIFTS=8:
  - 8 cycles of lfsr_shift_o=1 with gnt_o=0.
  - Then grants 001, 010, 100, 001 in consecutive cycles, each with rdata_o equal to that cycle's lfsr_data_i.
- Seed write 0x1234_5678 while in READY with req_i=3'b001:
  - Same cycle: lfsr_seed_we_o=1, lfsr_seed_o=0x12345678, gnt_o=0.
  - Then 8 WARMUP cycles before the next grant.
- lfsr_lockup_i=1 for one cycle in READY:
  - gnt_o=0 and lfsr_shift_o=0 that cycle.
  - alert_o=1 the next cycle only; WARMUP follows.
- seed_we_i and lfsr_lockup_i together: seed is applied, alert_o stays 0, and WARMUP is re-entered.
- enable_i=0 for 3 cycles mid-WARMUP with wcnt=5: wcnt stays at 5, and READY is reached 5 enabled cycles later.
- Fairness with req_i toggling 3'b101 every cycle and rr_ptr=1: grants are 100, 001, 100, 001. No requester waits more than NUM_REQ-1 grants.
